// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word SRAM responder for MEM-stage load/store requests
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   mem_read   load request, level, held until ready
//   mem_write  store request, level, held until ready (wins when both are set)
//   addr       byte address
//   wdata      store data
//   rdata      load result, holds until the next load completes
//   ready      request complete, or no request pending
//   error      last completed access was out of range or misaligned
//
// Optional feature macro: DMEM_POSTED_WRITE_EN (stores are acknowledged at once
// and drained in the background through a one-entry write buffer).
module dmem_responder #(
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [WORD_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  error
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [WORD_WIDTH-1:0] BASE = WORD_WIDTH'(ADDR_BASE);
    localparam logic [WORD_WIDTH-1:0] SPAN = WORD_WIDTH'(4 * DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

`ifdef DMEM_POSTED_WRITE_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE, WDRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

    state_t state, state_next;
    logic [3:0] cnt;
    logic [WORD_WIDTH-1:0] cap_addr, cap_wdata, offset;
    logic cap_write, capture, complete, legal;
    logic [IW-1:0] idx;
    logic [WORD_WIDTH-1:0] mem [DEPTH];
    wire req = mem_read | mem_write;

    // Decode works on the captured address so input changes while busy are ignored.
    assign offset = cap_addr - BASE;
    assign legal  = cap_addr >= BASE && offset < SPAN && cap_addr[1:0] == 2'b00;
    assign idx    = offset[IW+1:2];

    always_comb begin
        state_next = state;
        ready = 1'b0;
        capture = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                capture = req;
`ifdef DMEM_POSTED_WRITE_EN
                if (mem_write) begin
                    ready = 1'b1;
                    state_next = WDRAIN;
                end else if (mem_read) state_next = BUSY;
`else
                if (req) state_next = BUSY;
`endif
            end
            BUSY: if (cnt == 4'd0) begin
                complete = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                ready = 1'b1;
                state_next = IDLE;
            end
`ifdef DMEM_POSTED_WRITE_EN
            // New requests wait here; IDLE picks them up once the buffer is empty.
            WDRAIN: begin
                ready = ~req;
                if (cnt == 4'd0) begin
                    complete = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            rdata <= '0;
            error <= 1'b0;
            cap_addr <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                cap_addr <= addr;
                cap_wdata <= wdata;
                cap_write <= mem_write;
                cnt <= CNT_INIT;
            end else if (cnt != 4'd0) cnt <= cnt - 4'd1;
            if (complete) begin
                error <= ~legal;
                if (!cap_write) rdata <= legal ? mem[idx] : '0;
            end
        end
    end

    // complete is only raised outside reset, so an aborted store never lands.
    always_ff @(posedge clk)
        if (complete && cap_write && legal) mem[idx] <= cap_wdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
    localparam int W = 4;
`ifdef DMEM_POSTED_WRITE_EN
    localparam int ST_LAT = 0;
`else
    localparam int ST_LAT = W + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_read = 1'b0;
    logic mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic ready, error;
    int errors = 0;
    int checks = 0;
    int lat;

    dmem_responder #(.WORD_WIDTH(32), .DEPTH(64), .ADDR_BASE(1024), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns the cycle index in which ready rose.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int n);
        mem_read = rd;
        mem_write = wr;
        addr = a;
        wdata = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            n++;
            if (n > 50) begin
                errors++;
                $display("FAIL timeout: ready never rose, got %0d cycles, expected <= 50", n);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    // Stores are let drain fully so the following request sees a plain IDLE.
    task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d);
        access(1'b0, 1'b1, a, d, lat);
        check(tag, lat, ST_LAT);
`ifdef DMEM_POSTED_WRITE_EN
        repeat (W) @(posedge clk);
        #1;
`endif
    endtask

    task automatic load(input string tag, input logic [31:0] a,
                        input logic [31:0] exp_data, input logic exp_err);
        access(1'b1, 1'b0, a, 32'h0, lat);
        check({tag, "_lat"}, lat, W + 1);
        check({tag, "_data"}, rdata, exp_data);
        check({tag, "_err"}, 32'(error), 32'(exp_err));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_rdata", rdata, 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_ready", 32'(ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        store("st_1024_lat", 32'd1024, 32'hDEADBEEF);
        load("ld_1024", 32'd1024, 32'hDEADBEEF, 1'b0);

        // Reset in the middle of a store: write must be dropped, outputs cleared.
        mem_write = 1'b1;
        addr = 32'd1024;
        wdata = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_write = 1'b0;
        #2;
        check("abort_rdata", rdata, 32'h0);
        check("abort_error", 32'(error), 32'h0);
        check("abort_ready", 32'(ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(ready), 32'h1);
        load("ld_after_abort", 32'd1024, 32'hDEADBEEF, 1'b0);

        store("st_top_lat", 32'd1276, 32'h12345678);
        load("ld_top", 32'd1276, 32'h12345678, 1'b0);
        load("ld_past_end", 32'd1280, 32'h0, 1'b1);
        load("ld_below", 32'd1020, 32'h0, 1'b1);
        load("ld_misalign", 32'd1026, 32'h0, 1'b1);
        load("ld_1024_again", 32'd1024, 32'hDEADBEEF, 1'b0);

        // Both strobes set: behaves as a store and leaves rdata alone.
        access(1'b1, 1'b1, 32'd1028, 32'h55, lat);
        check("both_lat", lat, ST_LAT);
        check("both_rdata", rdata, 32'hDEADBEEF);
`ifdef DMEM_POSTED_WRITE_EN
        repeat (W) @(posedge clk);
        #1;
`endif
        check("both_rdata_held", rdata, 32'hDEADBEEF);
        load("ld_1028", 32'd1028, 32'h55, 1'b0);

        // Store followed immediately by a load of the same word.
        access(1'b0, 1'b1, 32'd1032, 32'hA5A5F00D, lat);
        check("b2b_st_lat", lat, ST_LAT);
        access(1'b1, 1'b0, 32'd1032, 32'h0, lat);
`ifdef DMEM_POSTED_WRITE_EN
        check("b2b_ld_lat", lat, 2 * W + 1);
`else
        check("b2b_ld_lat", lat, W + 1);
`endif
        check("b2b_ld_data", rdata, 32'hA5A5F00D);
        check("b2b_ld_err", 32'(error), 32'h0);
        load("ld_1024_final", 32'd1024, 32'hDEADBEEF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
